// File: rtl/rate_conv_pkg.sv
// Shared definitions for the 4-to-3 rate conversion stages (transmit and receive).
// Holds the framing FSM state encoding, default widths shared by both directions,
// and a helper for sizing small saturating counters.
package rate_conv_pkg;

  // Defaults shared with the 4-to-3 transmit stage.
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FRAME_LEN  = 4;

  // Receive-side defaults.
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_LOCK_CNT   = 3;
  localparam int DEF_MISS_CNT   = 2;

  // Framing FSM states.
  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } frame_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/destuff4to3_rx_if.sv
// Slot stream in / payload stream out for the 4-to-3 destuffer.
// master: the destuffer (consumes x/x_sync, drives y/y_valid, samples y_ready).
// slave : the surrounding logic (drives x/x_sync and y_ready, consumes y/y_valid).
interface destuff4to3_rx_if
  import rate_conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] x;        // incoming slot data, one slot per cycle
  logic              x_sync;   // high in the stuff slot of each frame
  logic [DATA_W-1:0] y;        // payload sample at FIFO head
  logic              y_valid;  // y holds a valid sample
  logic              y_ready;  // consumer accepts y this cycle

  modport master (
    input  x,
    input  x_sync,
    input  y_ready,
    output y,
    output y_valid
  );

  modport slave (
    output x,
    output x_sync,
    output y_ready,
    input  y,
    input  y_valid
  );

endinterface

// File: rtl/destuff4to3_rx_sync_fifo.sv
// Show-ahead payload FIFO with a registered head word.
// Latency: a word written at edge t appears on rd_data/!empty after edge t+1 when the FIFO was empty.
// Backpressure: rd_en stalls the head; a write into a full FIFO with no read is dropped and sets ovf.
// Ports: clk_div3, reset (sync, active-low); wr_en/wr_data/full; rd_en/rd_data/empty; ovf (sticky).
module sync_fifo
  import rate_conv_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk_div3,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_rd;
  logic              head_vld;
  logic [DATA_W-1:0] head_dat;
  logic              do_rd;
  logic              do_wr;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign do_rd = rd_en && head_vld;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  // Occupancy after this cycle's read but before this cycle's write: the head
  // register only ever shows words already stored before the current edge, which
  // keeps the head and the pointers consistent and gives the one-cycle write latency.
  assign count_rd   = count - CW'(do_rd);
  assign rd_ptr_nxt = rd_ptr + PW'(do_rd);

  always_ff @(posedge clk_div3) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_div3) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
      ovf      <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_rd + CW'(do_wr);
      // The slot being written this edge is never the next head while the head is
      // valid, so reading the array here sees settled data.
      head_vld <= (count_rd != '0);
      head_dat <= (count_rd != '0) ? mem[rd_ptr_nxt] : '0;
      if (wr_en && full && !do_rd) begin
        ovf <= 1'b1;
      end
    end
  end

  assign rd_data = head_dat;
  assign empty   = !head_vld;

endmodule

// File: rtl/destuff4to3_rx.sv
// Locks to the 4-to-3 slot framing, strips the stuff slot and queues payload for the consumer.
// Latency: payload sampled at edge t is on y after edge t+1 when the FIFO is empty; locked/stuff_err are registered.
// Backpressure: y_valid/y_ready; the input stream cannot stall, so payload arriving at a full FIFO is dropped (ovf).
// Ports: clk_div3, reset (sync, active-low); io (x, x_sync in; y, y_valid out; y_ready in);
//        locked, stuff_err (1-cycle pulse), ovf (sticky).
module destuff4to3_rx
  import rate_conv_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int MISS_CNT   = DEF_MISS_CNT
) (
  input  logic              clk_div3,
  input  logic              reset,
  destuff4to3_rx_if.master  io,
  output logic              locked,
  output logic              stuff_err,
  output logic              ovf
);

  localparam int CW = cnt_w(FRAME_LEN);
  localparam int GW = cnt_w(LOCK_CNT + 1);
  localparam int MW = cnt_w(MISS_CNT + 1);

  frame_state_t      state;
  frame_state_t      state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [CW-1:0]     cnt_inc;
  logic [GW-1:0]     good;
  logic [GW-1:0]     good_nxt;
  logic [MW-1:0]     miss;
  logic [MW-1:0]     miss_nxt;
  logic              stuff_err_nxt;
  logic              is_stuff;
  logic              wr_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_dat;

  assign is_stuff = (cnt == '0);
  assign cnt_inc  = (cnt == CW'(FRAME_LEN - 1)) ? '0 : cnt + CW'(1);

  always_ff @(posedge clk_div3) begin
    if (!reset) begin
      state     <= SEARCH;
      cnt       <= '0;
      good      <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      good      <= good_nxt;
      miss      <= miss_nxt;
      locked    <= (state_nxt == LOCKED);
      stuff_err <= stuff_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt_inc;
    good_nxt      = good;
    miss_nxt      = miss;
    stuff_err_nxt = 1'b0;
    wr_en         = 1'b0;

    case (state)
      SEARCH: begin
        if (io.x_sync) begin
          // The sync slot is slot 0, so the following slot is slot 1.
          cnt_nxt  = CW'(1);
          good_nxt = GW'(1);
          if (LOCK_CNT <= 1) begin
            state_nxt = LOCKED;
            miss_nxt  = '0;
          end else begin
            state_nxt = VERIFY;
          end
        end
      end

      VERIFY: begin
        if (is_stuff && io.x_sync) begin
          if (good >= GW'(LOCK_CNT - 1)) begin
            good_nxt  = GW'(LOCK_CNT);
            miss_nxt  = '0;
            state_nxt = LOCKED;
          end else begin
            good_nxt = good + GW'(1);
          end
        end else if (is_stuff || io.x_sync) begin
          // Missing or misplaced sync; a sync seen here is deliberately not reused
          // as the start of a new search, the counter just keeps running.
          good_nxt  = '0;
          state_nxt = SEARCH;
        end
      end

      LOCKED: begin
        wr_en = !is_stuff;
        if (is_stuff && io.x_sync) begin
          miss_nxt      = '0;
          stuff_err_nxt = (io.x != '0);
        end else if (is_stuff || io.x_sync) begin
          // A misplaced sync still lands in a payload slot, which is written above.
          if (miss >= MW'(MISS_CNT - 1)) begin
            miss_nxt  = MW'(MISS_CNT);
            good_nxt  = '0;
            state_nxt = SEARCH;
          end else begin
            miss_nxt = miss + MW'(1);
          end
        end
      end

      default: begin
        state_nxt = SEARCH;
      end
    endcase
  end

  // Losing lock does not flush: already accepted payload keeps draining.
  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_div3 (clk_div3),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (io.x),
    .full     (fifo_full),
    .rd_en    (io.y_ready),
    .rd_data  (head_dat),
    .empty    (fifo_empty),
    .ovf      (ovf)
  );

  assign io.y       = head_dat;
  assign io.y_valid = !fifo_empty;

endmodule

// File: tb/tb_destuff4to3_rx.sv
// Self-checking bench for destuff4to3_rx: scenario tasks drive framed slot streams,
// expected payload words are queued as they are driven and compared as they leave y.
module tb_destuff4to3_rx;

  logic clk_div3;
  logic reset;
  logic locked;
  logic stuff_err;
  logic ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  int pay    = 1;

  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  destuff4to3_rx_if #(.DATA_W(8)) io ();

  destuff4to3_rx dut (
    .clk_div3  (clk_div3),
    .reset     (reset),
    .io        (io),
    .locked    (locked),
    .stuff_err (stuff_err),
    .ovf       (ovf)
  );

  initial clk_div3 = 1'b0;
  always #5 clk_div3 = ~clk_div3;

  // Inputs only change just after a rising edge, so at the falling edge the
  // handshake seen here is exactly what the next rising edge acts on.
  always @(negedge clk_div3) begin
    if (reset === 1'b1 && io.y_valid === 1'b1 && io.y_ready === 1'b1) begin
      n_chk++;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL y_unexpected: got %h, required no output", io.y);
      end else begin
        exp_v = exp_q.pop_front();
        if (io.y !== exp_v) begin
          n_fail++;
          $display("FAIL y_data: got %h, required %h", io.y, exp_v);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One slot: drive, optionally expect it as payload, advance one edge, settle.
  task automatic slot(input logic [7:0] d, input logic s, input bit wr);
    io.x      = d;
    io.x_sync = s;
    if (wr) exp_q.push_back(d);
    @(posedge clk_div3);
    #1;
  endtask

  task automatic pay_slot(input bit wr);
    logic [7:0] v;
    v   = pay[7:0];
    pay = (pay >= 255) ? 1 : pay + 1;
    if (pay == 'h5A) pay++;
    slot(v, 1'b0, wr);
  endtask

  // Stuff slot then three payload slots; mask bit i: payload slot i+1 expected on y.
  task automatic send_frame(input logic s, input logic [7:0] stuff, input logic [2:0] mask,
                            output logic lk0, output logic se0, output logic se1);
    slot(stuff, s, 1'b0);
    lk0 = locked;
    se0 = stuff_err;
    pay_slot(mask[0]);
    se1 = stuff_err;
    pay_slot(mask[1]);
    pay_slot(mask[2]);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    exp_q.delete();
    repeat (n) slot(8'h00, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) slot(8'h00, 1'b0, 1'b0);
  endtask

  // From LOCKED with miss==0: first missed sync keeps lock, second drops it.
  task automatic lose_lock();
    logic a, b, c;
    send_frame(1'b0, 8'h00, 3'b111, a, b, c);
    send_frame(1'b0, 8'h00, 3'b000, a, b, c);
  endtask

  task automatic relock(input logic [2:0] last_mask);
    logic a, b, c;
    send_frame(1'b1, 8'h00, 3'b000, a, b, c);
    send_frame(1'b1, 8'h00, 3'b000, a, b, c);
    send_frame(1'b1, 8'h00, last_mask, a, b, c);
  endtask

  task automatic test_reset();
    io.y_ready = 1'b1;
    apply_reset(2);
    n_chk++; if (io.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b, required 0", io.y_valid); end
    n_chk++; if (io.y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h, required 00", io.y); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b, required 0", locked); end
    n_chk++; if (stuff_err !== 1'b0) begin n_fail++; $display("FAIL reset_stuff_err: got %b, required 0", stuff_err); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
  endtask

  task automatic test_clean_lock();
    logic lk, se0, se1;
    io.y_ready = 1'b1;
    send_frame(1'b1, 8'h00, 3'b000, lk, se0, se1);
    n_chk++; if (lk !== 1'b0) begin n_fail++; $display("FAIL lock_sync1: got %b, required 0", lk); end
    send_frame(1'b1, 8'h00, 3'b000, lk, se0, se1);
    n_chk++; if (lk !== 1'b0) begin n_fail++; $display("FAIL lock_sync2: got %b, required 0", lk); end
    send_frame(1'b1, 8'h00, 3'b111, lk, se0, se1);
    n_chk++; if (lk !== 1'b1) begin n_fail++; $display("FAIL lock_sync3: got %b, required 1", lk); end
    repeat (3) send_frame(1'b1, 8'h00, 3'b111, lk, se0, se1);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got %b, required 1", locked); end
    n_chk++; if (se0 !== 1'b0) begin n_fail++; $display("FAIL clean_stuff_err: got %b, required 0", se0); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clean_ovf: got %b, required 0", ovf); end
  endtask

  task automatic test_sync_drop();
    logic lk, se0, se1;
    send_frame(1'b0, 8'h00, 3'b111, lk, se0, se1);
    n_chk++; if (lk !== 1'b1) begin n_fail++; $display("FAIL one_miss_locked: got %b, required 1", lk); end
    send_frame(1'b1, 8'h00, 3'b111, lk, se0, se1);
    send_frame(1'b0, 8'h00, 3'b111, lk, se0, se1);
    n_chk++; if (lk !== 1'b1) begin n_fail++; $display("FAIL first_of_two_miss: got %b, required 1", lk); end
    send_frame(1'b0, 8'h00, 3'b000, lk, se0, se1);
    n_chk++; if (lk !== 1'b0) begin n_fail++; $display("FAIL second_miss_unlock: got %b, required 0", lk); end
    drain(40);
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL unlock_drain: %0d words left, required 0", exp_q.size()); end
    n_chk++; if (io.y_valid !== 1'b0) begin n_fail++; $display("FAIL unlock_drain_valid: got %b, required 0", io.y_valid); end
  endtask

  task automatic test_stuff_err();
    logic lk, se0, se1;
    relock(3'b111);
    send_frame(1'b1, 8'h5A, 3'b111, lk, se0, se1);
    n_chk++; if (se0 !== 1'b1) begin n_fail++; $display("FAIL stuff_err_pulse: got %b, required 1", se0); end
    n_chk++; if (se1 !== 1'b0) begin n_fail++; $display("FAIL stuff_err_width: got %b, required 0", se1); end
    n_chk++; if (lk !== 1'b1) begin n_fail++; $display("FAIL stuff_err_locked: got %b, required 1", lk); end
    lose_lock();
    drain(40);
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stuff_drain: %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic lk, se0, se1;
    int p0;
    io.y_ready = 1'b0;
    relock(3'b111);
    send_frame(1'b1, 8'h00, 3'b111, lk, se0, se1);
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b, required 0", ovf); end
    // Words 7 and 8 fill the FIFO, word 9 is dropped.
    send_frame(1'b1, 8'h00, 3'b011, lk, se0, se1);
    n_chk++; if (io.y_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b, required 1", io.y_valid); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", ovf); end
    send_frame(1'b0, 8'h00, 3'b000, lk, se0, se1);
    send_frame(1'b0, 8'h00, 3'b000, lk, se0, se1);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL ovf_unlock: got %b, required 0", locked); end
    p0 = n_pop;
    io.y_ready = 1'b1;
    drain(40);
    n_chk++; if (n_pop - p0 != 8) begin n_fail++; $display("FAIL ovf_drain_count: got %0d words, required 8", n_pop - p0); end
    n_chk++; if (io.y_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_valid: got %b, required 0", io.y_valid); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", ovf); end
  endtask

  task automatic test_full_rw();
    logic lk, se0, se1;
    apply_reset(2);
    io.y_ready = 1'b0;
    relock(3'b111);
    send_frame(1'b1, 8'h00, 3'b111, lk, se0, se1);
    slot(8'h00, 1'b1, 1'b0);
    pay_slot(1'b1);
    pay_slot(1'b1);
    n_chk++; if (io.y_valid !== 1'b1) begin n_fail++; $display("FAIL rw_full_valid: got %b, required 1", io.y_valid); end
    // Full FIFO, read and write in the same cycle: nothing may be lost.
    io.y_ready = 1'b1;
    pay_slot(1'b1);
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rw_no_ovf: got %b, required 0", ovf); end
    send_frame(1'b1, 8'h00, 3'b111, lk, se0, se1);
    lose_lock();
    drain(40);
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rw_drain: %0d words left, required 0", exp_q.size()); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rw_ovf_end: got %b, required 0", ovf); end
  endtask

  task automatic test_reset_mid_drain();
    logic lk, se0, se1;
    io.y_ready = 1'b0;
    relock(3'b111);
    slot(8'h00, 1'b1, 1'b0);
    pay_slot(1'b1);
    pay_slot(1'b1);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL pre_reset_locked: got %b, required 1", locked); end
    io.y_ready = 1'b1;
    apply_reset(1);
    n_chk++; if (io.y_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b, required 0", io.y_valid); end
    n_chk++; if (io.y !== 8'h00) begin n_fail++; $display("FAIL mid_reset_y: got %h, required 00", io.y); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_reset_locked: got %b, required 0", locked); end
    slot(8'h00, 1'b0, 1'b0);
    n_chk++; if (io.y_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_stale: got %b, required 0", io.y_valid); end
    send_frame(1'b1, 8'h00, 3'b000, lk, se0, se1);
    n_chk++; if (lk !== 1'b0) begin n_fail++; $display("FAIL relock_sync1: got %b, required 0", lk); end
    send_frame(1'b1, 8'h00, 3'b000, lk, se0, se1);
    n_chk++; if (lk !== 1'b0) begin n_fail++; $display("FAIL relock_sync2: got %b, required 0", lk); end
    send_frame(1'b1, 8'h00, 3'b111, lk, se0, se1);
    n_chk++; if (lk !== 1'b1) begin n_fail++; $display("FAIL relock_sync3: got %b, required 1", lk); end
    lose_lock();
    drain(40);
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL relock_drain: %0d words left, required 0", exp_q.size()); end
  endtask

  initial begin
    reset      = 1'b0;
    io.x       = 8'h00;
    io.x_sync  = 1'b0;
    io.y_ready = 1'b1;
    test_reset();
    test_clean_lock();
    test_sync_drop();
    test_stuff_err();
    test_overflow();
    test_full_rw();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
